mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 151 +++++++++++++++
 tb/tb_mem_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (instruction fetch, data) onto one shared memory port.
// Alternates on ties and aborts a transfer that waits TIMEOUT cycles for mem_ack.
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 8'd64,
    parameter int unsigned TO_W    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [9:0]  if_addr,
    output logic        if_done,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [11:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_done,
    output logic [31:0] dm_rdata,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [11:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        err
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_BUSY_IF = 2'd1;
    localparam logic [1:0] S_BUSY_DM = 2'd2;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    logic [1:0]      state_q, state_d;
    logic            last_dm_q, last_dm_d;   // 0: IF granted last, 1: DM granted last
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [11:0]     mem_addr_q, mem_addr_d;
    logic [31:0]     mem_wdata_q, mem_wdata_d;
    logic            if_done_q, if_done_d, dm_done_q, dm_done_d;
    logic [31:0]     if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
    logic            err_q, err_d;
    logic            if_v, dm_v, gnt_dm, is_dm;

    // A requester whose done is high is still holding req for the finished access.
    assign if_v   = if_req & ~if_done_q;
    assign dm_v   = dm_req & ~dm_done_q;
    assign gnt_dm = dm_v & (~if_v | ~last_dm_q);
    assign is_dm  = (state_q == S_BUSY_DM);

    always_comb begin
        state_d     = state_q;
        last_dm_d   = last_dm_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_done_d   = 1'b0;
        dm_done_d   = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        err_d       = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (gnt_dm) begin
                    state_d     = S_BUSY_DM;
                    mem_req_d   = 1'b1;
                    mem_we_d    = dm_we;
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
                    cnt_d       = '0;
                end else if (if_v) begin
                    state_d    = S_BUSY_IF;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = {if_addr, 2'b00};
                    cnt_d      = '0;
                end
            end
            S_BUSY_IF, S_BUSY_DM: begin
                if (mem_ack) begin
                    state_d   = S_IDLE;
                    mem_req_d = 1'b0;
                    last_dm_d = is_dm;
                    if (is_dm) begin
                        dm_done_d = 1'b1;
                        if (!mem_we_q) dm_rdata_d = mem_rdata;
                    end else begin
                        if_done_d  = 1'b1;
                        if_rdata_d = mem_rdata;
                    end
                end else if (cnt_q == TO_LAST) begin
                    state_d   = S_IDLE;
                    mem_req_d = 1'b0;
                    err_d     = 1'b1;
                    if (is_dm) begin
                        dm_done_d  = 1'b1;
                        dm_rdata_d = '0;
                    end else begin
                        if_done_d  = 1'b1;
                        if_rdata_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            last_dm_q   <= 1'b0;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_done_q   <= 1'b0;
            dm_done_q   <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_dm_q   <= last_dm_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_done_q   <= if_done_d;
            dm_done_q   <= dm_done_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            err_q       <= err_d;
        end
    end

    assign stall     = (if_req & ~if_done_q) | (dm_req & ~dm_done_q);
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_done   = if_done_q;
    assign dm_done   = dm_done_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign err       = err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic against a
// transaction-level reference model of the arbitration and timeout rules.
module tb_mem_arbiter;
    localparam int TIMEOUT = 64;

    logic        clk, rst;
    logic        if_req, if_done, dm_req, dm_we, dm_done, stall;
    logic        mem_req, mem_we, mem_ack, err;
    logic [9:0]  if_addr;
    logic [11:0] dm_addr, mem_addr;
    logic [31:0] if_rdata, dm_wdata, dm_rdata, mem_wdata, mem_rdata;

    mem_arbiter #(.TIMEOUT(TIMEOUT), .TO_W(8)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_done(dm_done), .dm_rdata(dm_rdata), .stall(stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0, n_fail = 0;

    // Reference model: who owns the port (0 none, 1 IF, 2 DM), who was served last,
    // how many busy cycles the current transfer has waited, and the visible results.
    int          mo_owner, mo_last, mo_busy;
    logic        mo_if_done, mo_dm_done, mo_err, mo_we;
    logic [11:0] mo_addr;
    logic [31:0] mo_wdata, mo_if_rd, mo_dm_rd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mo_owner = 0; mo_last = 1; mo_busy = 0;
        mo_if_done = 0; mo_dm_done = 0; mo_err = 0; mo_we = 0;
        mo_addr = '0; mo_wdata = '0; mo_if_rd = '0; mo_dm_rd = '0;
    endtask

    task automatic model_edge();
        bit ifv, dmv, nd_if, nd_dm;
        nd_if = 0; nd_dm = 0;
        ifv = if_req && !mo_if_done;
        dmv = dm_req && !mo_dm_done;
        if (mo_owner == 0) begin
            if (dmv && (!ifv || mo_last == 1)) begin
                mo_owner = 2; mo_addr = dm_addr; mo_we = dm_we; mo_wdata = dm_wdata; mo_busy = 0;
            end else if (ifv) begin
                mo_owner = 1; mo_addr = {if_addr, 2'b00}; mo_we = 0; mo_busy = 0;
            end
        end else begin
            mo_busy++;
            if (mem_ack) begin
                if (mo_owner == 1) begin nd_if = 1; mo_if_rd = mem_rdata; end
                else begin nd_dm = 1; if (!mo_we) mo_dm_rd = mem_rdata; end
                mo_last = mo_owner; mo_owner = 0;
            end else if (mo_busy == TIMEOUT) begin
                mo_err = 1;
                if (mo_owner == 1) begin nd_if = 1; mo_if_rd = '0; end
                else begin nd_dm = 1; mo_dm_rd = '0; end
                mo_owner = 0;
            end
        end
        mo_if_done = nd_if; mo_dm_done = nd_dm;
    endtask

    // Called at a negedge with inputs already applied; returns at the next negedge.
    task automatic step();
        #1;
        chk("stall", 32'(stall), 32'((if_req && !mo_if_done) || (dm_req && !mo_dm_done)));
        @(posedge clk);
        model_edge();
        #1;
        chk("mem_req", 32'(mem_req), 32'(mo_owner != 0));
        chk("if_done", 32'(if_done), 32'(mo_if_done));
        chk("dm_done", 32'(dm_done), 32'(mo_dm_done));
        chk("if_rdata", if_rdata, mo_if_rd);
        chk("dm_rdata", dm_rdata, mo_dm_rd);
        chk("err", 32'(err), 32'(mo_err));
        if (mo_owner != 0) begin
            chk("mem_addr", 32'(mem_addr), 32'(mo_addr));
            chk("mem_we", 32'(mem_we), 32'(mo_we));
            if (mo_owner == 2 && mo_we) chk("mem_wdata", mem_wdata, mo_wdata);
        end
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_mem_req"}, 32'(mem_req), 0);
        chk({tag, "_mem_we"}, 32'(mem_we), 0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_dones"}, 32'({if_done, dm_done}), 0);
        chk({tag, "_rdata"}, if_rdata | dm_rdata, 0);
        chk({tag, "_err"}, 32'(err), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        #1 chk_reset_outputs("rst");
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic rand_drive();
        if (!if_req) begin
            if ($urandom_range(2) == 0) begin if_req = 1; if_addr = 10'($urandom); end
        end else if (mo_if_done) begin
            if ($urandom_range(1) == 1) if_req = 0; else if_addr = 10'($urandom);
        end else if (mo_owner == 1) if_addr = 10'($urandom);
        if (!dm_req) begin
            if ($urandom_range(2) == 0) begin
                dm_req = 1; dm_we = 1'($urandom); dm_addr = 12'($urandom); dm_wdata = $urandom;
            end
        end else if (mo_dm_done) begin
            if ($urandom_range(1) == 1) dm_req = 0;
            else begin dm_we = 1'($urandom); dm_addr = 12'($urandom); dm_wdata = $urandom; end
        end else if (mo_owner == 2) begin
            dm_addr = 12'($urandom); dm_wdata = $urandom; dm_we = 1'($urandom);
        end
        mem_ack   = ($urandom_range(3) != 0);
        mem_rdata = $urandom;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 0; if_req = 0; if_addr = '0; dm_req = 0; dm_we = 0; dm_addr = '0;
        dm_wdata = '0; mem_ack = 0; mem_rdata = '0;
        model_reset();
        #3 chk_reset_outputs("init");
        @(negedge clk);
        rst = 1;

        // Single fetch, ack one cycle after mem_req.
        if_req = 1; if_addr = 10'h005;
        step();
        chk("fetch_addr", 32'(mem_addr), 32'h014);
        chk("fetch_we", 32'(mem_we), 0);
        mem_ack = 1; mem_rdata = 32'hCAFE_0001;
        step();
        chk("fetch_rdata", if_rdata, 32'hCAFE_0001);
        if_req = 0; mem_ack = 0;
        step();

        // Simultaneous requests from reset: DM first, then IF.
        do_reset();
        if_req = 1; if_addr = 10'h003;
        dm_req = 1; dm_we = 1; dm_addr = 12'h100; dm_wdata = 32'h1234_5678;
        mem_ack = 1; mem_rdata = 32'h0BAD_F00D;
        step();
        chk("tie_first_we", 32'(mem_we), 1);
        chk("tie_first_addr", 32'(mem_addr), 32'h100);
        for (int i = 0; i < 7; i++) begin
            step();
            chk("tie_both_done", 32'(if_done & dm_done), 0);
            if (mo_dm_done) dm_req = 0;
            if (mo_if_done) if_req = 0;
        end

        // Back-to-back with both held: grants go DM, IF, DM.
        if_req = 1; if_addr = 10'h001; dm_req = 1; dm_we = 0; dm_addr = 12'h0A8; mem_ack = 1;
        step(); chk("b2b_g1", 32'(mem_addr), 32'h0A8);
        step();
        step(); chk("b2b_g2", 32'(mem_addr), 32'h004);
        step();
        step(); chk("b2b_g3", 32'(mem_addr), 32'h0A8);
        step();
        if_req = 0; dm_req = 0;
        step();

        // Randomized traffic, including acks arriving while idle.
        for (int i = 0; i < 1500; i++) begin
            rand_drive();
            step();
        end

        // Drain, then stray acks in IDLE.
        if_req = 0; dm_req = 0; mem_ack = 1;
        for (int i = 0; i < 200 && mo_owner != 0; i++) step();
        step();
        chk("drain_idle", 32'(mem_req), 0);
        for (int i = 0; i < 3; i++) begin
            mem_rdata = $urandom;
            step();
            chk("stray_done", 32'({if_done, dm_done}), 0);
        end

        // Timeout with ack tied low.
        do_reset();
        if_req = 1; if_addr = 10'h2AA; mem_ack = 0;
        n = 0;
        while (n < 80 && !if_done) begin step(); n++; end
        chk("to_latency", 32'(n), 32'(TIMEOUT + 1));
        chk("to_rdata", if_rdata, 0);
        chk("to_err", 32'(err), 1);
        if_req = 0;
        for (int i = 0; i < 5; i++) begin
            mem_ack = 1'($urandom);
            step();
        end
        chk("to_err_sticky", 32'(err), 1);

        // Reset in the middle of a DM transfer.
        do_reset();
        dm_req = 1; dm_we = 0; dm_addr = 12'h0FC; mem_ack = 0;
        step(); step(); step();
        chk("mid_busy", 32'(mem_req), 1);
        #2;
        rst = 0; dm_req = 0;
        #1 chk("mid_async_req", 32'(mem_req), 0);
        chk_reset_outputs("mid");
        model_reset();
        @(negedge clk);
        rst = 1; mem_ack = 1;
        for (int i = 0; i < 6; i++) step();
        if_req = 1; if_addr = 10'h011;
        step();
        chk("post_rst_grant", 32'(mem_req), 1);
        step();
        if_req = 0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
